nco_bank: RTL and testbench

Parametrised multi-channel numerically controlled oscillator, the successor to the single fixed-increment `nco_sig`. Holds N_CH independent phase accumulators, each with its own phase increment loaded at run time through a valid/ready configuration port. Channels support immediate or phase-continuous (at-wrap) increment updates, a linear frequency sweep, and stop/hold. Sits between the control logic and the TX/NCO square-wave outputs (accumulator MSB → PLL_TX / pins).

---
 rtl/nco_pkg.sv | 12 +
 rtl/nco_chan.sv | 70 +++++++
 rtl/nco_bank.sv | 93 +++++++++
 tb/tb_nco_bank.sv | 276 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/nco_pkg.sv
// nco_pkg: shared mode codes, channel state type and default width for the NCO bank
package nco_pkg;
    localparam logic [1:0] MODE_RUN   = 2'd0;
    localparam logic [1:0] MODE_SWEEP = 2'd1;
    localparam logic [1:0] MODE_STOP  = 2'd2;
    localparam int ACC_W_DEF = 64;
    typedef enum logic [1:0] {ST_STOP, ST_RUN, ST_SWEEP} chan_state_t;
    // The reserved mode code falls through to STOP.
    function automatic chan_state_t mode_to_state(input logic [1:0] m);
        return (m == MODE_RUN) ? ST_RUN : (m == MODE_SWEEP) ? ST_SWEEP : ST_STOP;
    endfunction
endpackage

// File: rtl/nco_chan.sv
// nco_chan: one phase accumulator with run/sweep/stop control and wrap/done pulses
//   clk, rst_n                 clock, async active-low reset
//   i_wr                       load i_mode/i_inc/i_step/i_limit this edge
//   o_acc                      accumulator register
//   o_wrap, o_done             registered overflow / sweep-complete pulses
//   o_carry                    overflow of the addition happening at this edge
//   o_stopped                  channel is in STOP (no addition, never carries)
module nco_chan import nco_pkg::*; #(
    parameter int ACC_W = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_wr,
    input  logic [1:0]       i_mode,
    input  logic [ACC_W-1:0] i_inc,
    input  logic [ACC_W-1:0] i_step,
    input  logic [ACC_W-1:0] i_limit,
    output logic [ACC_W-1:0] o_acc,
    output logic             o_wrap,
    output logic             o_done,
    output logic             o_carry,
    output logic             o_stopped
);
    chan_state_t      r_state;
    logic [ACC_W-1:0] r_acc, r_inc, r_step, r_limit;
    logic             r_wrap, r_done;
    logic [ACC_W:0]   w_sum, w_inc_nxt;
    logic             w_run, w_sat;

    // Sums carry one extra bit so overflow and the sweep limit compare see the carry.
    always_comb begin
        w_run     = r_state != ST_STOP;
        w_sum     = {1'b0, r_acc} + {1'b0, r_inc};
        w_inc_nxt = {1'b0, r_inc} + {1'b0, r_step};
        w_sat     = (r_state == ST_SWEEP) && (w_inc_nxt >= {1'b0, r_limit});
        o_acc     = r_acc;
        o_wrap    = r_wrap;
        o_done    = r_done;
        o_carry   = w_run & w_sum[ACC_W];
        o_stopped = !w_run;
    end

    // The addition at a load edge still uses the old increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_STOP;
            r_acc   <= '0;
            r_inc   <= '0;
            r_step  <= '0;
            r_limit <= '0;
            r_wrap  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            if (w_run) r_acc <= w_sum[ACC_W-1:0];
            r_wrap <= w_run & w_sum[ACC_W];
            r_done <= w_sat & !i_wr;
            if (i_wr) begin
                r_state <= mode_to_state(i_mode);
                r_inc   <= i_inc;
                r_step  <= i_step;
                r_limit <= i_limit;
            end else if (w_sat) begin
                r_inc   <= r_limit;
                r_state <= ST_RUN;
            end else if (r_state == ST_SWEEP) begin
                r_inc <= w_inc_nxt[ACC_W-1:0];
            end
        end
    end
endmodule

// File: rtl/nco_bank.sv
// nco_bank: N_CH-channel NCO with valid/ready config port and wrap-synchronised staging
//   clk, rst_n                 clock, async active-low reset
//   cfg_valid/cfg_ready        config handshake; ready is low while a synced word is staged
//   cfg_ch, cfg_mode, cfg_sync target channel, RUN/SWEEP/STOP, apply-at-wrap flag
//   cfg_inc/cfg_step/cfg_limit increment, sweep step, sweep end increment
//   phase_accum                channel i at [i*ACC_W +: ACC_W]
//   sq_out, wrap, sweep_done   per-channel MSB, overflow pulse, sweep-complete pulse
module nco_bank import nco_pkg::*; #(
    parameter  int N_CH  = 2,
    parameter  int ACC_W = ACC_W_DEF,
    localparam int CH_W  = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  cfg_valid,
    output logic                  cfg_ready,
    input  logic [CH_W-1:0]       cfg_ch,
    input  logic [1:0]            cfg_mode,
    input  logic                  cfg_sync,
    input  logic [ACC_W-1:0]      cfg_inc,
    input  logic [ACC_W-1:0]      cfg_step,
    input  logic [ACC_W-1:0]      cfg_limit,
    output logic [N_CH*ACC_W-1:0] phase_accum,
    output logic [N_CH-1:0]       sq_out,
    output logic [N_CH-1:0]       wrap,
    output logic [N_CH-1:0]       sweep_done
);
    logic             r_stg_valid;
    logic [CH_W-1:0]  r_stg_ch;
    logic [1:0]       r_stg_mode;
    logic [ACC_W-1:0] r_stg_inc, r_stg_step, r_stg_limit;
    logic             w_accept, w_ch_ok;
    logic [1:0]       w_mode;
    logic [ACC_W-1:0] w_inc, w_step, w_limit;
    logic [N_CH-1:0]  w_carry, w_stopped, w_apply, w_wr;

    // While staging is full no new word is accepted, so the staged word and an
    // immediate write can never target the channels in the same cycle.
    always_comb begin
        cfg_ready = !r_stg_valid;
        w_accept  = cfg_valid & cfg_ready;
        w_ch_ok   = {1'b0, cfg_ch} < (CH_W + 1)'(N_CH);
        w_mode    = r_stg_valid ? r_stg_mode  : cfg_mode;
        w_inc     = r_stg_valid ? r_stg_inc   : cfg_inc;
        w_step    = r_stg_valid ? r_stg_step  : cfg_step;
        w_limit   = r_stg_valid ? r_stg_limit : cfg_limit;
        w_apply   = '0;
        w_wr      = '0;
        for (int i = 0; i < N_CH; i++) begin
            // A stopped channel never carries, so its staged word applies right away.
            w_apply[i] = r_stg_valid && (r_stg_ch == CH_W'(i)) && (w_carry[i] || w_stopped[i]);
            w_wr[i]    = w_apply[i] || (w_accept && !cfg_sync && (cfg_ch == CH_W'(i)));
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_valid <= 1'b0;
            r_stg_ch    <= '0;
            r_stg_mode  <= MODE_STOP;
            r_stg_inc   <= '0;
            r_stg_step  <= '0;
            r_stg_limit <= '0;
        end else if (|w_apply) begin
            r_stg_valid <= 1'b0;
        end else if (w_accept && cfg_sync && w_ch_ok) begin
            r_stg_valid <= 1'b1;
            r_stg_ch    <= cfg_ch;
            r_stg_mode  <= cfg_mode;
            r_stg_inc   <= cfg_inc;
            r_stg_step  <= cfg_step;
            r_stg_limit <= cfg_limit;
        end
    end

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        nco_chan #(.ACC_W(ACC_W)) u_chan (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_wr      (w_wr[g]),
            .i_mode    (w_mode),
            .i_inc     (w_inc),
            .i_step    (w_step),
            .i_limit   (w_limit),
            .o_acc     (phase_accum[g*ACC_W +: ACC_W]),
            .o_wrap    (wrap[g]),
            .o_done    (sweep_done[g]),
            .o_carry   (w_carry[g]),
            .o_stopped (w_stopped[g])
        );
        assign sq_out[g] = phase_accum[g*ACC_W + ACC_W - 1];
    end
endmodule

// File: tb/tb_nco_bank.sv
// tb_nco_bank: directed scenario tests for nco_bank (8-bit 2-ch, 8-bit 3-ch, 64-bit 1-ch)
module tb_nco_bank;
    import nco_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        v8 = 1'b0, v3 = 1'b0, v64 = 1'b0;
    logic        sync = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [1:0]  ch = 2'd0;
    logic [63:0] inc = '0, step = '0, limit = '0;

    logic        rdy8, rdy3, rdy64;
    logic [15:0] acc8;
    logic [1:0]  sq8, wr8, dn8;
    logic [23:0] acc3;
    logic [2:0]  sq3, wr3, dn3;
    logic [63:0] acc64;
    logic [0:0]  sq64, wr64, dn64;

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    nco_bank #(.N_CH(2), .ACC_W(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v8), .cfg_ready(rdy8), .cfg_ch(ch[0:0]),
        .cfg_mode(mode), .cfg_sync(sync), .cfg_inc(inc[7:0]), .cfg_step(step[7:0]),
        .cfg_limit(limit[7:0]), .phase_accum(acc8), .sq_out(sq8), .wrap(wr8), .sweep_done(dn8)
    );

    nco_bank #(.N_CH(3), .ACC_W(8)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v3), .cfg_ready(rdy3), .cfg_ch(ch),
        .cfg_mode(mode), .cfg_sync(sync), .cfg_inc(inc[7:0]), .cfg_step(step[7:0]),
        .cfg_limit(limit[7:0]), .phase_accum(acc3), .sq_out(sq3), .wrap(wr3), .sweep_done(dn3)
    );

    nco_bank #(.N_CH(1), .ACC_W(64)) u_dut64 (
        .clk(clk), .rst_n(rst_n), .cfg_valid(v64), .cfg_ready(rdy64), .cfg_ch(ch[0:0]),
        .cfg_mode(mode), .cfg_sync(sync), .cfg_inc(inc), .cfg_step(step),
        .cfg_limit(limit), .phase_accum(acc64), .sq_out(sq64), .wrap(wr64), .sweep_done(dn64)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_all;
        rst_n = 1'b0;
        v8 = 1'b0; v3 = 1'b0; v64 = 1'b0;
        repeat (2) tick;
        rst_n = 1'b1;
        tick;
    endtask

    // Presents one config word to the selected bench instance for exactly one edge.
    task automatic send(input int d, input logic [1:0] m, input logic s, input logic [1:0] c,
                        input logic [63:0] i, input logic [63:0] st, input logic [63:0] l);
        mode = m; sync = s; ch = c; inc = i; step = st; limit = l;
        v8 = (d == 8); v3 = (d == 3); v64 = (d == 64);
        tick;
        v8 = 1'b0; v3 = 1'b0; v64 = 1'b0;
    endtask

    task automatic test_reset;
        reset_all;
        checks++;
        if ({rdy8, rdy3, rdy64} !== 3'b111) $display("FAIL reset_ready: got %b expected 111", {rdy8, rdy3, rdy64});
        else passed++;
        checks++;
        if ({acc8, acc3, acc64} !== '0) $display("FAIL reset_acc: got %h %h %h expected 0", acc8, acc3, acc64);
        else passed++;
        checks++;
        if ({sq8, wr8, dn8, sq3, wr3, dn3, sq64, wr64, dn64} !== '0)
            $display("FAIL reset_pulses: got %b expected 0", {sq8, wr8, dn8, sq3, wr3, dn3, sq64, wr64, dn64});
        else passed++;
    endtask

    task automatic test_run;
        logic [7:0] e;
        send(8, MODE_RUN, 1'b0, 2'd0, 64'h40, 64'h0, 64'h0);
        checks++;
        if (acc8 !== 16'h0000) $display("FAIL run_accept_acc: got %h expected 0000", acc8);
        else passed++;
        for (int k = 0; k < 8; k++) begin
            tick;
            e = 8'((k + 1) * 8'h40);
            checks++;
            if ({acc8, wr8[0], sq8[0]} !== {8'h00, e, (k % 4 == 3), e[7]})
                $display("FAIL run_cycle%0d: got acc=%h wrap=%b sq=%b expected acc=%h wrap=%b sq=%b",
                         k, acc8, wr8[0], sq8[0], {8'h00, e}, (k % 4 == 3), e[7]);
            else passed++;
        end
    endtask

    task automatic test_sync;
        logic [7:0] ea[6] = '{8'h80, 8'hC0, 8'h00, 8'h20, 8'h40, 8'h60};
        logic       er[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        logic       ew[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        send(8, MODE_RUN, 1'b1, 2'd0, 64'h20, 64'h0, 64'h0);
        checks++;
        if ({rdy8, acc8[7:0]} !== {1'b0, 8'h40}) $display("FAIL sync_accept: got rdy=%b acc=%h expected rdy=0 acc=40", rdy8, acc8[7:0]);
        else passed++;
        for (int k = 0; k < 6; k++) begin
            tick;
            checks++;
            if ({acc8[7:0], rdy8, wr8[0]} !== {ea[k], er[k], ew[k]})
                $display("FAIL sync_cycle%0d: got acc=%h rdy=%b wrap=%b expected acc=%h rdy=%b wrap=%b",
                         k, acc8[7:0], rdy8, wr8[0], ea[k], er[k], ew[k]);
            else passed++;
        end
    endtask

    task automatic test_sweep;
        logic [7:0] ea[6] = '{8'h10, 8'h30, 8'h60, 8'hA0, 8'hE0, 8'h20};
        logic       ed[6] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0};
        logic       ew[6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        int dones = 0;
        reset_all;
        send(8, MODE_SWEEP, 1'b0, 2'd1, 64'h10, 64'h10, 64'h40);
        checks++;
        if (acc8 !== 16'h0000) $display("FAIL sweep_accept_acc: got %h expected 0000", acc8);
        else passed++;
        for (int k = 0; k < 6; k++) begin
            tick;
            dones += int'(dn8[1]);
            checks++;
            if ({acc8[15:8], dn8[1], wr8[1]} !== {ea[k], ed[k], ew[k]})
                $display("FAIL sweep_cycle%0d: got acc=%h done=%b wrap=%b expected acc=%h done=%b wrap=%b",
                         k, acc8[15:8], dn8[1], wr8[1], ea[k], ed[k], ew[k]);
            else passed++;
        end
        checks++;
        if (dones !== 1) $display("FAIL sweep_done_count: got %0d expected 1", dones);
        else passed++;
        // Limit below the start increment saturates on the first sweep edge.
        reset_all;
        send(8, MODE_SWEEP, 1'b0, 2'd1, 64'h30, 64'h05, 64'h20);
        tick;
        checks++;
        if ({acc8[15:8], dn8[1]} !== {8'h30, 1'b1}) $display("FAIL sweep_low_limit_first: got acc=%h done=%b expected acc=30 done=1", acc8[15:8], dn8[1]);
        else passed++;
        tick;
        tick;
        checks++;
        if ({acc8[15:8], dn8[1]} !== {8'h70, 1'b0}) $display("FAIL sweep_low_limit_run: got acc=%h done=%b expected acc=70 done=0", acc8[15:8], dn8[1]);
        else passed++;
    endtask

    task automatic test_stop;
        reset_all;
        send(8, MODE_RUN, 1'b0, 2'd0, 64'h30, 64'h0, 64'h0);
        tick;
        tick;
        send(8, MODE_STOP, 1'b0, 2'd0, 64'h30, 64'h0, 64'h0);
        checks++;
        if (acc8[7:0] !== 8'h90) $display("FAIL stop_entry_acc: got %h expected 90", acc8[7:0]);
        else passed++;
        for (int k = 0; k < 3; k++) begin
            tick;
            checks++;
            if ({acc8[7:0], wr8[0]} !== {8'h90, 1'b0}) $display("FAIL stop_hold%0d: got acc=%h wrap=%b expected acc=90 wrap=0", k, acc8[7:0], wr8[0]);
            else passed++;
        end
        send(8, MODE_RUN, 1'b0, 2'd0, 64'h30, 64'h0, 64'h0);
        tick;
        tick;
        checks++;
        if ({acc8[7:0], wr8[0]} !== {8'hF0, 1'b0}) $display("FAIL stop_resume: got acc=%h wrap=%b expected acc=f0 wrap=0", acc8[7:0], wr8[0]);
        else passed++;
        tick;
        checks++;
        if ({acc8[7:0], wr8[0]} !== {8'h20, 1'b1}) $display("FAIL stop_resume_wrap: got acc=%h wrap=%b expected acc=20 wrap=1", acc8[7:0], wr8[0]);
        else passed++;
        send(8, 2'd3, 1'b0, 2'd0, 64'h30, 64'h0, 64'h0);
        tick;
        tick;
        checks++;
        if (acc8[7:0] !== 8'h50) $display("FAIL reserved_mode_stop: got %h expected 50", acc8[7:0]);
        else passed++;
    endtask

    task automatic test_back_to_back;
        reset_all;
        send(8, MODE_RUN, 1'b0, 2'd0, 64'h10, 64'h0, 64'h0);
        send(8, MODE_RUN, 1'b0, 2'd1, 64'h20, 64'h0, 64'h0);
        tick;
        checks++;
        if (acc8 !== 16'h2020) $display("FAIL back_to_back: got %h expected 2020", acc8);
        else passed++;
    endtask

    task automatic test_bad_channel;
        reset_all;
        send(3, MODE_RUN, 1'b0, 2'd3, 64'h40, 64'h0, 64'h0);
        repeat (3) tick;
        checks++;
        if ({rdy3, acc3, wr3, sq3} !== {1'b1, 30'h0}) $display("FAIL bad_ch_imm: got rdy=%b acc=%h wrap=%b expected rdy=1 acc=0 wrap=0", rdy3, acc3, wr3);
        else passed++;
        send(3, MODE_RUN, 1'b1, 2'd3, 64'h40, 64'h0, 64'h0);
        checks++;
        if (rdy3 !== 1'b1) $display("FAIL bad_ch_sync_ready: got %b expected 1", rdy3);
        else passed++;
        tick;
        checks++;
        if (acc3 !== 24'h0) $display("FAIL bad_ch_sync_acc: got %h expected 000000", acc3);
        else passed++;
        send(3, MODE_RUN, 1'b0, 2'd2, 64'h40, 64'h0, 64'h0);
        tick;
        checks++;
        if (acc3 !== 24'h400000) $display("FAIL good_ch2: got %h expected 400000", acc3);
        else passed++;
    endtask

    task automatic test_async_reset;
        reset_all;
        send(8, MODE_RUN, 1'b0, 2'd0, 64'h40, 64'h0, 64'h0);
        repeat (3) tick;
        send(8, MODE_RUN, 1'b1, 2'd0, 64'h10, 64'h0, 64'h0);
        checks++;
        if ({acc8[7:0], wr8[0], rdy8} !== {8'h00, 1'b1, 1'b0}) $display("FAIL areset_pending: got acc=%h wrap=%b rdy=%b expected acc=00 wrap=1 rdy=0", acc8[7:0], wr8[0], rdy8);
        else passed++;
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({acc8, wr8, sq8, dn8, rdy8} !== {22'h0, 1'b1}) $display("FAIL areset_clear: got acc=%h wrap=%b sq=%b rdy=%b expected acc=0 wrap=0 sq=0 rdy=1", acc8, wr8, sq8, rdy8);
        else passed++;
        #2 rst_n = 1'b1;
        repeat (3) tick;
        checks++;
        if ({acc8, rdy8} !== {16'h0, 1'b1}) $display("FAIL areset_stage_lost: got acc=%h rdy=%b expected acc=0000 rdy=1", acc8, rdy8);
        else passed++;
    endtask

    task automatic test_wide;
        int wraps = 0;
        int highs = 0;
        reset_all;
        send(64, MODE_RUN, 1'b0, 2'd0, 64'h3D00_0000_0000_0000, 64'h0, 64'h0);
        tick;
        checks++;
        if (acc64 !== 64'h3D00_0000_0000_0000) $display("FAIL wide_first: got %h expected 3d00000000000000", acc64);
        else passed++;
        wraps += int'(wr64[0]);
        for (int k = 1; k < 16384; k++) begin
            tick;
            wraps += int'(wr64[0]);
            highs += int'(sq64[0]);
        end
        // 16384 * 61/256 = 3904 overflows, final phase returns exactly to 0.
        checks++;
        if (wraps < 3903 || wraps > 3905) $display("FAIL wide_wraps: got %0d expected 3904", wraps);
        else passed++;
        checks++;
        if (acc64 !== 64'h0) $display("FAIL wide_final_acc: got %h expected 0", acc64);
        else passed++;
        checks++;
        if (highs < 8000 || highs > 8384) $display("FAIL wide_duty: got %0d high cycles expected about 8192", highs);
        else passed++;
    endtask

    initial begin
        test_reset;
        test_run;
        test_sync;
        test_sweep;
        test_stop;
        test_back_to_back;
        test_bad_channel;
        test_async_reset;
        test_wide;
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
